// File: rtl/mem_port_arbiter.sv
// Two-port arbiter and sequencer for the shared byte-addressable memory port.
// Port 0 is the core, port 1 the debug/program loader. Each access is granted,
// issued for one cycle, then waits a fixed read latency or until the memory
// reports write completion (with timeout), and finally acks the requester.
// Ports:
//   clk, rst                     clock, async active-low reset
//   mN_req/addr/wmode/wdata      requester N inputs (sampled only in IDLE)
//   mN_gnt/ack/rdata/err         requester N responses (registered)
//   mem_address/write_mode/wdata memory command (registered)
//   mem_done/error/rdata         memory status and read data
module mem_port_arbiter #(
   parameter  int unsigned READ_LATENCY = 2,
   parameter  int unsigned WR_TIMEOUT   = 255,
   localparam int unsigned AW           = 32,
   localparam int unsigned DW           = 32,
   localparam int unsigned MW           = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic [AW-1:0] m0_addr,
   input  logic [MW-1:0] m0_wmode,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_ack,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_err,
   input  logic          m1_req,
   input  logic [AW-1:0] m1_addr,
   input  logic [MW-1:0] m1_wmode,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_ack,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_err,
   output logic [AW-1:0] mem_address,
   output logic [MW-1:0] mem_write_mode,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_done,
   input  logic          mem_error,
   input  logic [DW-1:0] mem_rdata
);

   localparam int unsigned CW = 8;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ISSUE      = 3'd1,
      READ_WAIT  = 3'd2,
      WRITE_WAIT = 3'd3,
      RESP       = 3'd4
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic          win;
   logic          last_grant;
   logic [MW-1:0] wmode_q;
   logic          err_q;

   logic          pick_c;
   logic          grant_c;
   logic          resp_c;
   logic          capture_c;
   logic          timeout_c;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       if (m0_req || m1_req) state_nxt = ISSUE;
         ISSUE: begin
            if (mem_error)           state_nxt = RESP;
            else if (wmode_q == '0)  state_nxt = READ_WAIT;
            else                     state_nxt = WRITE_WAIT;
         end
         READ_WAIT:  if (cnt == '0) state_nxt = RESP;
         WRITE_WAIT: if (mem_done || (cnt >= CW'(WR_TIMEOUT))) state_nxt = RESP;
         RESP:       state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Output/strobe decode; on a tie the port that did not win last time goes
   always_comb begin
      pick_c    = 1'b0;
      if (m0_req && m1_req) pick_c = ~last_grant;
      else                  pick_c = m1_req;
      grant_c   = (state == IDLE) && (m0_req || m1_req);
      resp_c    = (state == RESP);
      capture_c = (state == READ_WAIT) && (cnt == '0);
      // cnt holds the number of WRITE_WAIT cycles including the current one
      timeout_c = (state == WRITE_WAIT) && !mem_done && (cnt >= CW'(WR_TIMEOUT));
   end

   // Registered outputs and access context
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m0_gnt         <= 1'b0;
         m1_gnt         <= 1'b0;
         m0_ack         <= 1'b0;
         m1_ack         <= 1'b0;
         m0_rdata       <= '0;
         m1_rdata       <= '0;
         m0_err         <= 1'b0;
         m1_err         <= 1'b0;
         mem_address    <= '0;
         mem_write_mode <= '0;
         mem_wdata      <= '0;
         cnt            <= '0;
         win            <= 1'b0;
         last_grant     <= 1'b1;
         wmode_q        <= '0;
         err_q          <= 1'b0;
      end else begin
         m0_gnt <= grant_c & ~pick_c;
         m1_gnt <= grant_c &  pick_c;
         m0_ack <= resp_c  & ~win;
         m1_ack <= resp_c  &  win;

         if (grant_c) begin
            win         <= pick_c;
            mem_address <= pick_c ? m1_addr  : m0_addr;
            mem_wdata   <= pick_c ? m1_wdata : m0_wdata;
            wmode_q     <= pick_c ? m1_wmode : m0_wmode;
            err_q       <= 1'b0;
         end

         case (state)
            ISSUE: begin
               if (mem_error) begin
                  err_q <= 1'b1;
               end else if (wmode_q == '0) begin
                  cnt <= CW'(READ_LATENCY - 1);
               end else begin
                  cnt            <= CW'(1);
                  mem_write_mode <= wmode_q;
               end
            end
            READ_WAIT: begin
               if (capture_c) begin
                  if (win) m1_rdata <= mem_rdata;
                  else     m0_rdata <= mem_rdata;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            WRITE_WAIT: begin
               if (mem_done || timeout_c) mem_write_mode <= '0;
               if (timeout_c) err_q <= 1'b1;
               if (cnt != '1) cnt <= cnt + CW'(1);
            end
            RESP: begin
               last_grant <= win;
               if (win) m1_err <= err_q;
               else     m0_err <= err_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: reset, read, write, round-robin,
// alignment error, write timeout and reset during a write.
module tb_mem_port_arbiter;

   localparam int TB_WR_TIMEOUT = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req,  m1_req;
   logic [31:0] m0_addr, m1_addr;
   logic [1:0]  m0_wmode, m1_wmode;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_gnt,  m1_gnt, m0_ack, m1_ack, m0_err, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] mem_address, mem_wdata, mem_rdata;
   logic [1:0]  mem_write_mode;
   logic        mem_done, mem_error;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.READ_LATENCY(2), .WR_TIMEOUT(TB_WR_TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wmode(m0_wmode), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wmode(m1_wmode), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .mem_address(mem_address), .mem_write_mode(mem_write_mode), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_error(mem_error), .mem_rdata(mem_rdata)
   );

   task automatic do_reset();
      rst = 1'b0;
      m0_req = 1'b0; m1_req = 1'b0;
      m0_addr = '0; m1_addr = '0; m0_wmode = '0; m1_wmode = '0;
      m0_wdata = '0; m1_wdata = '0;
      mem_done = 1'b0; mem_error = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++;
      if ({m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_strobes: got %b want 000000", {m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err});
      end
      tests_run++;
      if ({m0_rdata, m1_rdata} !== 64'h0) begin
         tests_failed++;
         $display("FAIL reset_rdata: got %h/%h want 0/0", m0_rdata, m1_rdata);
      end
      tests_run++;
      if ({mem_address, mem_wdata, mem_write_mode} !== 66'h0) begin
         tests_failed++;
         $display("FAIL reset_mem: got %h %h %0d want 0", mem_address, mem_wdata, mem_write_mode);
      end
   endtask

   task automatic test_read();
      int g, a, other;
      logic mode_seen;
      logic [31:0] addr_at_ack;
      g = -1; a = -1; other = 0; mode_seen = 1'b0; addr_at_ack = '0;
      m0_addr = 32'h0000_0010; m0_wmode = 2'd0; m0_wdata = 32'hFFFF_FFFF;
      mem_rdata = 32'hDEAD_BEEF; m0_req = 1'b1;
      for (int i = 0; i < 20 && a < 0; i++) begin
         @(negedge clk);
         if (mem_write_mode != 2'd0) mode_seen = 1'b1;
         if (m1_gnt || m1_ack) other++;
         if (m0_gnt) begin g = i; m0_req = 1'b0; m0_addr = 32'hBAD0_0000; end
         if (m0_ack) begin a = i; addr_at_ack = mem_address; end
      end
      tests_run++;
      if (g !== 0) begin tests_failed++; $display("FAIL read_gnt_latency: got %0d want 0", g); end
      tests_run++;
      if (a - g !== 4) begin tests_failed++; $display("FAIL read_ack_latency: got %0d want 4", a - g); end
      tests_run++;
      if (m0_rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL read_rdata: got %h want deadbeef", m0_rdata); end
      tests_run++;
      if (m0_err !== 1'b0) begin tests_failed++; $display("FAIL read_err: got %b want 0", m0_err); end
      tests_run++;
      if (addr_at_ack !== 32'h0000_0010) begin tests_failed++; $display("FAIL read_addr_latched: got %h want 00000010", addr_at_ack); end
      tests_run++;
      if (mode_seen !== 1'b0) begin tests_failed++; $display("FAIL read_write_mode: got nonzero want 0"); end
      tests_run++;
      if (other !== 0 || m1_rdata !== 32'h0) begin
         tests_failed++; $display("FAIL read_other_port: got %0d strobes rdata %h want 0/0", other, m1_rdata);
      end
   endtask

   task automatic test_write();
      int g, a, mode3, other;
      logic [31:0] addr_seen, wdata_seen;
      logic mode_after;
      g = -1; a = -1; mode3 = 0; other = 0; addr_seen = '0; wdata_seen = '0; mode_after = 1'b1;
      m1_addr = 32'h0000_0100; m1_wmode = 2'd3; m1_wdata = 32'h1234_5678;
      mem_done = 1'b0; m1_req = 1'b1;
      for (int i = 0; i < 20 && a < 0; i++) begin
         @(negedge clk);
         if (mem_write_mode == 2'd3) mode3++;
         if (i == 1) begin addr_seen = mem_address; wdata_seen = mem_wdata; end
         if (i == 4) begin mode_after = (mem_write_mode != 2'd0); mem_done = 1'b0; end
         if (i == 3) mem_done = 1'b1;
         if (m0_gnt || m0_ack) other++;
         if (m1_gnt) begin g = i; m1_req = 1'b0; m1_wdata = '0; end
         if (m1_ack) a = i;
      end
      mem_done = 1'b0;
      tests_run++;
      if (g !== 0 || a !== 5) begin tests_failed++; $display("FAIL write_timing: got gnt %0d ack %0d want 0/5", g, a); end
      tests_run++;
      if (mode3 !== 3) begin tests_failed++; $display("FAIL write_mode_cycles: got %0d want 3", mode3); end
      tests_run++;
      if (mode_after !== 1'b0) begin tests_failed++; $display("FAIL write_mode_drop: got nonzero want 0"); end
      tests_run++;
      if (addr_seen !== 32'h0000_0100 || wdata_seen !== 32'h1234_5678) begin
         tests_failed++; $display("FAIL write_cmd: got %h %h want 00000100 12345678", addr_seen, wdata_seen);
      end
      tests_run++;
      if (m1_err !== 1'b0) begin tests_failed++; $display("FAIL write_err: got %b want 0", m1_err); end
      tests_run++;
      if (m1_rdata !== 32'h0) begin tests_failed++; $display("FAIL write_rdata_hold: got %h want 0", m1_rdata); end
      tests_run++;
      if (other !== 0 || m0_rdata !== 32'hDEAD_BEEF) begin
         tests_failed++; $display("FAIL write_other_port: got %0d strobes rdata %h want 0/deadbeef", other, m0_rdata);
      end
   endtask

   task automatic test_back_to_back();
      int ng, a0, a1, both;
      logic [2:0] order;
      ng = 0; a0 = 0; a1 = 0; both = 0; order = '0;
      do_reset();
      m0_addr = 32'h20; m1_addr = 32'h24; m0_wmode = 2'd0; m1_wmode = 2'd0;
      m0_req = 1'b1; m1_req = 1'b1;
      for (int i = 0; i < 60 && (a0 + a1) < 3; i++) begin
         @(negedge clk);
         if (m0_gnt && m1_gnt) both++;
         if (m0_ack && m1_ack) both++;
         if ((m0_gnt || m1_gnt) && ng < 3) begin
            order[ng] = m1_gnt;
            mem_rdata = 32'h1000 + 32'(ng);
            ng++;
            if (ng == 3) begin m0_req = 1'b0; m1_req = 1'b0; end
         end
         if (m0_ack) a0++;
         if (m1_ack) a1++;
      end
      m0_req = 1'b0; m1_req = 1'b0;
      tests_run++;
      if (order !== 3'b010 || ng !== 3) begin tests_failed++; $display("FAIL rr_order: got %b (%0d) want 010 (3)", order, ng); end
      tests_run++;
      if (both !== 0) begin tests_failed++; $display("FAIL rr_exclusive: got %0d want 0", both); end
      tests_run++;
      if (a0 !== 2 || a1 !== 1) begin tests_failed++; $display("FAIL rr_acks: got %0d/%0d want 2/1", a0, a1); end
      tests_run++;
      if (m0_rdata !== 32'h1002) begin tests_failed++; $display("FAIL rr_m0_rdata: got %h want 00001002", m0_rdata); end
      tests_run++;
      if (m1_rdata !== 32'h1001) begin tests_failed++; $display("FAIL rr_m1_rdata: got %h want 00001001", m1_rdata); end
   endtask

   task automatic test_align_err();
      int g, a;
      logic mode_seen;
      g = -1; a = -1; mode_seen = 1'b0;
      m0_addr = 32'h3; m0_wmode = 2'd2; m0_wdata = 32'h0000_BEEF;
      mem_error = 1'b1; m0_req = 1'b1;
      for (int i = 0; i < 20 && a < 0; i++) begin
         @(negedge clk);
         if (mem_write_mode != 2'd0) mode_seen = 1'b1;
         if (m0_gnt) begin g = i; m0_req = 1'b0; end
         if (m0_ack) a = i;
      end
      mem_error = 1'b0;
      tests_run++;
      if (a - g !== 2 || g < 0) begin tests_failed++; $display("FAIL align_latency: got %0d want 2", a - g); end
      tests_run++;
      if (m0_err !== 1'b1) begin tests_failed++; $display("FAIL align_err: got %b want 1", m0_err); end
      tests_run++;
      if (mode_seen !== 1'b0) begin tests_failed++; $display("FAIL align_no_write: got nonzero want 0"); end
      tests_run++;
      if (m0_rdata !== 32'h1002 || m1_err !== 1'b0) begin
         tests_failed++; $display("FAIL align_hold: got %h err1 %b want 00001002/0", m0_rdata, m1_err);
      end
   endtask

   task automatic test_err_clears();
      int a;
      a = -1;
      m0_addr = 32'h40; m0_wmode = 2'd0; mem_rdata = 32'h55AA_55AA; m0_req = 1'b1;
      for (int i = 0; i < 20 && a < 0; i++) begin
         @(negedge clk);
         if (m0_gnt) m0_req = 1'b0;
         if (m0_ack) a = i;
      end
      tests_run++;
      if (m0_err !== 1'b0 || a < 0) begin tests_failed++; $display("FAIL err_clear: got %b ack %0d want 0", m0_err, a); end
      tests_run++;
      if (m0_rdata !== 32'h55AA_55AA) begin tests_failed++; $display("FAIL err_clear_rdata: got %h want 55aa55aa", m0_rdata); end
   endtask

   task automatic test_timeout();
      int g, a, entry, nz;
      g = -1; a = -1; entry = -1; nz = 0;
      m1_addr = 32'h200; m1_wmode = 2'd3; m1_wdata = 32'hCAFE_F00D;
      mem_done = 1'b0; m1_req = 1'b1;
      for (int i = 0; i < 400 && a < 0; i++) begin
         @(negedge clk);
         if (mem_write_mode != 2'd0) begin nz++; if (entry < 0) entry = i; end
         if (m1_gnt) begin g = i; m1_req = 1'b0; end
         if (m1_ack) a = i;
      end
      tests_run++;
      if (entry - g !== 1 || g < 0) begin tests_failed++; $display("FAIL timeout_entry: got %0d want 1", entry - g); end
      tests_run++;
      if (a - entry !== TB_WR_TIMEOUT + 1 || a < 0) begin
         tests_failed++; $display("FAIL timeout_latency: got %0d want %0d", a - entry, TB_WR_TIMEOUT + 1);
      end
      tests_run++;
      if (nz !== TB_WR_TIMEOUT) begin tests_failed++; $display("FAIL timeout_mode_cycles: got %0d want %0d", nz, TB_WR_TIMEOUT); end
      tests_run++;
      if (m1_err !== 1'b1) begin tests_failed++; $display("FAIL timeout_err: got %b want 1", m1_err); end
   endtask

   task automatic test_reset_mid_write();
      int entry, g, a, first, m1acks;
      entry = -1; g = -1; a = -1; first = -1; m1acks = 0;
      m1_addr = 32'h300; m1_wmode = 2'd3; m1_wdata = 32'hA5A5_A5A5;
      mem_done = 1'b0; m1_req = 1'b1;
      for (int i = 0; i < 10 && entry < 0; i++) begin
         @(negedge clk);
         if (m1_gnt) m1_req = 1'b0;
         if (mem_write_mode != 2'd0) entry = i;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if (mem_write_mode !== 2'd0 || entry < 0) begin
         tests_failed++; $display("FAIL rst_mode_drop: got %0d entry %0d want 0", mem_write_mode, entry);
      end
      tests_run++;
      if ({m0_ack, m1_ack, m0_gnt, m1_gnt} !== 4'b0) begin
         tests_failed++; $display("FAIL rst_strobes: got %b want 0000", {m0_ack, m1_ack, m0_gnt, m1_gnt});
      end
      m0_addr = 32'h50; m1_addr = 32'h54; m0_wmode = 2'd0; m1_wmode = 2'd0;
      m0_req = 1'b1; m1_req = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 20 && a < 0; i++) begin
         @(negedge clk);
         if (m1_ack) m1acks++;
         if ((m0_gnt || m1_gnt) && first < 0) begin
            first = m1_gnt ? 1 : 0; g = i; m0_req = 1'b0; m1_req = 1'b0;
         end
         if (m0_ack) a = i;
      end
      m0_req = 1'b0; m1_req = 1'b0;
      tests_run++;
      if (first !== 0) begin tests_failed++; $display("FAIL rst_tie_winner: got %0d want 0", first); end
      tests_run++;
      if (m1acks !== 0 || a - g !== 4) begin
         tests_failed++; $display("FAIL rst_after_access: got m1 acks %0d latency %0d want 0/4", m1acks, a - g);
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_align_err();
      test_err_clears();
      test_timeout();
      test_reset_mid_write();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
